data_mem_port: RTL and testbench

//  Load/store access unit between the multicycle core (MEMADR/MEMWRITE/MEMREAD states) and

---
 rtl/data_mem_port_pkg.sv | 42 ++++
 rtl/data_mem_port_byte_lane_merge.sv | 38 +++
 rtl/data_mem_port.sv | 111 +++++++++++
 tb/tb_data_mem_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_port_pkg.sv
// Shared types and constants for the data memory load/store port.
// Holds the funct3 width encodings, the FSM state enum and the fault rule.
package data_mem_port_pkg;

    localparam int XLEN   = 32;
    localparam int LANE_W = 8;
    localparam int LANE_N = XLEN / LANE_W;

    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } dmp_state_t;

    // Unsigned widths exist only for loads; halves need even, words need 4-byte alignment.
    function automatic logic access_fault(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic f;
        f = 1'b0;
        case (funct3)
            MW_B:    f = 1'b0;
            MW_BU:   f = write;
            MW_H:    f = addr_lo[0];
            MW_HU:   f = write | addr_lo[0];
            MW_W:    f = (addr_lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/data_mem_port_byte_lane_merge.sv
// Combinational lane logic: merges store data into a word and extracts/extends loads.
// Alignment is assumed already checked by the caller.
module byte_lane_merge
    import data_mem_port_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] merged_word,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        merged_word = old_word;
        case (funct3[1:0])
            2'b00:   merged_word[{addr_lo, 3'b000} +: LANE_W]     = store_data[LANE_W-1:0];
            2'b01:   merged_word[{addr_lo[1], 4'b0000} +: 2*LANE_W] = store_data[2*LANE_W-1:0];
            default: merged_word = store_data;
        endcase
    end

    // Aligned halves have addr_lo[0]=0, so one byte-granular shift serves both widths.
    always_comb begin
        shifted   = old_word >> {addr_lo, 3'b000};
        load_data = shifted;
        case (funct3)
            MW_B:    load_data = {{(XLEN-LANE_W){shifted[LANE_W-1]}}, shifted[LANE_W-1:0]};
            MW_BU:   load_data = {{(XLEN-LANE_W){1'b0}}, shifted[LANE_W-1:0]};
            MW_H:    load_data = {{(XLEN-2*LANE_W){shifted[2*LANE_W-1]}}, shifted[2*LANE_W-1:0]};
            MW_HU:   load_data = {{(XLEN-2*LANE_W){1'b0}}, shifted[2*LANE_W-1:0]};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// Load/store access unit between the multicycle core and word-organised memory.
// One access at a time: read-modify-write for sb/sh, direct write for sw, extract for loads.
module data_mem_port
    import data_mem_port_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // Request and response both transfer on a cycle where valid and ready are high together;
    // valid, once raised by the producer, holds its payload stable until that cycle.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output dmp_state_t        dbg_state
);

    dmp_state_t        state_q, state_d;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              fault_q;
    logic              req_fire;
    logic              req_fault;
    logic [XLEN-1:0]   merged_word;
    logic [XLEN-1:0]   load_data;

    assign req_fire  = req_valid && (state_q == ST_IDLE);
    assign req_fault = access_fault(req_write, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_fault)                          state_d = ST_RESP;
                    else if (req_write && req_funct3 == MW_W) state_d = ST_WRITE;
                    else                                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  state_d = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (req_fire) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                fault_q  <= req_fault;
            end
            if (state_q == ST_WAIT) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    byte_lane_merge u_lane (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .old_word    (rdata_q),
        .store_data  (wdata_q),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // mem_we is decoded from state so an asynchronous reset removes it immediately.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_fault = rsp_valid && fault_q;
    assign rsp_rdata = (rsp_valid && !write_q && !fault_q) ? load_data : '0;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_wdata = merged_word;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with a small registered-read word memory model.
module tb_data_mem_port;
    import data_mem_port_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    dmp_state_t  dbg_state;

    logic [31:0] mem [0:15];
    logic [31:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_cyc = 0;

    data_mem_port dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // memory model: registered read, word write
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[5:2]];
        if (mem_we) mem[mem_addr[5:2]] = mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt = we_cnt + 1;
            we_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one request; returns at the negedge where rsp_valid is first seen.
    // lat and wlat count cycles with the cycle right after the accept edge as 1.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int wlat);
        int n;
        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        n = cyc;
        req_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - n + 1;
                break;
            end
        end
        wlat = we_cyc - n + 1;
        check_eq("rsp_arrived", 32'(lat < 0), 32'd0);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a);
        int lat, wlat;
        do_req(1'b0, f3, a, 32'h0, lat, wlat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
        check_eq(tag, rsp_rdata, exp_q.pop_front());
        check_eq({tag, "_fault"}, 32'(rsp_fault), 32'd0);
    endtask

    task automatic fault_chk(input string tag, input logic w, input logic [2:0] f3,
                             input logic [31:0] a);
        int lat, wlat, w0;
        w0 = we_cnt;
        do_req(w, f3, a, 32'h5555_5555, lat, wlat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd1);
        check_eq({tag, "_fault"}, 32'(rsp_fault), 32'd1);
        check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
        @(negedge clk);
        check_eq({tag, "_no_we"}, 32'(we_cnt - w0), 32'd0);
    endtask

    initial begin
        int lat, wlat, w0;
        logic [31:0] held;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1111_1111 * i;
        mem[11] = 32'hdeadbeef;
        mem[12] = 32'hcafebabe;

        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // sw 256 @44
        w0 = we_cnt;
        do_req(1'b1, 3'b010, 32'd44, 32'd256, lat, wlat);
        check_eq("sw_lat", 32'(lat), 32'd2);
        check_eq("sw_we_lat", 32'(wlat), 32'd1);
        check_eq("sw_we_cnt", 32'(we_cnt - w0), 32'd1);
        check_eq("sw_fault", 32'(rsp_fault), 32'd0);
        check_eq("sw_rdata", rsp_rdata, 32'h0);
        check_eq("sw_mem11", mem[11], 32'd256);

        // sb 0xAB @49
        w0 = we_cnt;
        do_req(1'b1, 3'b000, 32'd49, 32'h0000_00ab, lat, wlat);
        check_eq("sb_lat", 32'(lat), 32'd4);
        check_eq("sb_we_lat", 32'(wlat), 32'd3);
        check_eq("sb_we_cnt", 32'(we_cnt - w0), 32'd1);
        check_eq("sb_mem12", mem[12], 32'hcafeabbe);

        // sh 0x1234 @50
        mem[12] = 32'hcafebabe;
        w0 = we_cnt;
        do_req(1'b1, 3'b001, 32'd50, 32'h0000_1234, lat, wlat);
        check_eq("sh_lat", 32'(lat), 32'd4);
        check_eq("sh_we_cnt", 32'(we_cnt - w0), 32'd1);
        check_eq("sh_mem12", mem[12], 32'h1234babe);
        check_eq("sh_mem11", mem[11], 32'd256);
        check_eq("sh_mem13", mem[13], 32'hdddddddd);

        // loads
        mem[11] = 32'hdeadbeef;
        exp_q.push_back(32'hffffffde); load_chk("lb47", 3'b000, 32'd47);
        exp_q.push_back(32'h000000de); load_chk("lbu47", 3'b100, 32'd47);
        exp_q.push_back(32'h0000dead); load_chk("lhu46", 3'b101, 32'd46);
        exp_q.push_back(32'hffffbeef); load_chk("lh44", 3'b001, 32'd44);
        exp_q.push_back(32'h000000be); load_chk("lbu45", 3'b100, 32'd45);
        exp_q.push_back(32'hdeadbeef); load_chk("lw44", 3'b010, 32'd44);
        exp_q.push_back(32'hffffffff); load_chk("lw_top", 3'b010, 32'hffff_fffc);

        // faults
        fault_chk("sw46", 1'b1, 3'b010, 32'd46);
        fault_chk("f3_011", 1'b0, 3'b011, 32'd44);
        fault_chk("sh49", 1'b1, 3'b001, 32'd49);
        fault_chk("lh45", 1'b0, 3'b001, 32'd45);
        fault_chk("sbu", 1'b1, 3'b100, 32'd44);
        check_eq("fault_mem11", mem[11], 32'hdeadbeef);

        // reset during WAIT of an sb
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'd49; req_wdata = 32'h0000_0077;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_wait", 32'(dbg_state), 32'(ST_WAIT));
        reset = 1'b1;
        #1;
        check_eq("rst_mid_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_mid_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_mid_we_cnt", 32'(we_cnt - w0), 32'd0);
        check_eq("rst_mid_mem12", mem[12], 32'h1234babe);
        check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mid_rsp", 32'(rsp_valid), 32'd0);

        // response backpressure
        rsp_ready = 1'b0;
        exp_q.push_back(32'h1234babe);
        do_req(1'b0, 3'b010, 32'd48, 32'h0, lat, wlat);
        held = rsp_rdata;
        check_eq("bp_rdata", held, exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_stable", rsp_rdata, 32'h1234babe);
            check_eq("bp_not_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_same_cycle", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("bp_released", 32'(rsp_valid), 32'd0);
        check_eq("bp_ready_next", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
